// File: rtl/vta_queue_unpacker.sv
// Unpacks wide queue words into RATIO narrower ready/valid beats, least-significant slice first.
// A last-beat handoff reloads the next word in the same cycle, so whole words stream without bubbles.
module vta_queue_unpacker #(
    parameter int IN_W  = 128,
    parameter int OUT_W = 32,
    localparam int RATIO = IN_W / OUT_W,
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1
) (
    input  logic             clock,
    input  logic             reset,
    output logic             io_in_ready,
    input  logic             io_in_valid,
    input  logic [IN_W-1:0]  io_in_bits,
    input  logic             io_flush,
    input  logic             io_out_ready,
    output logic             io_out_valid,
    output logic [OUT_W-1:0] io_out_bits,
    output logic             io_out_last,
    output logic [IDX_W-1:0] io_out_idx
);

    typedef enum logic {EMPTY, DRAIN} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    state_t           state;
    state_t           next_state;
    logic [IDX_W-1:0] idx;
    logic [IN_W-1:0]  hold;
    logic             at_last;
    logic             out_fire;
    logic             in_fire;

    assign at_last  = (state == DRAIN) && (idx == LAST_IDX);
    assign out_fire = (state == DRAIN) && io_out_ready;
    assign in_fire  = io_in_valid && io_in_ready;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Flush wins over a simultaneous last-beat reload.
    always_comb begin
        next_state = state;
        if (io_flush) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY: if (io_in_valid) next_state = DRAIN;
                DRAIN: if (out_fire && at_last && !io_in_valid) next_state = EMPTY;
                default: next_state = EMPTY;
            endcase
        end
    end

    always_comb begin
        io_out_valid = (state == DRAIN);
        io_out_last  = at_last;
        io_out_idx   = idx;
        io_out_bits  = '0;
        if (state == DRAIN) begin
            io_out_bits = hold[int'(idx) * OUT_W +: OUT_W];
        end
        io_in_ready  = reset && !io_flush && ((state == EMPTY) || (out_fire && at_last));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            idx  <= '0;
            hold <= '0;
        end else if (io_flush) begin
            idx <= '0;
        end else if (in_fire) begin
            hold <= io_in_bits;
            idx  <= '0;
        end else if (out_fire) begin
            idx <= at_last ? '0 : idx + IDX_W'(1);
        end
    end

endmodule
